// File: rtl/iir_band_sequencer.sv
// -----------------------------------------------------------------------------
// iir_band_sequencer
//
// Time-multiplexes one shared biquad IIR engine across NBANDS cascaded
// equalizer bands, once per audio sample. Each accepted sample is pushed
// through band 0..NBANDS-1 in turn, and each band's result becomes the next
// band's input. The final result is published with a one-cycle valid pulse.
// The block also owns a double-buffered coefficient bank. The host writes the
// shadow bank and requests a commit. The whole bank is copied to the active
// bank only while the sequencer is idle, so a sample never sees a mix of old
// and new coefficients.
//
// Ports
//   clk                 system clock
//   i_rst               synchronous reset, active-high
//   i_sample_strobe     one-cycle pulse per new sample
//   i_sample            signed input sample, valid with the strobe
//   i_valid             1 = filter the sample, 0 = bypass (sampled at strobe)
//   i_cfg_we            shadow coefficient write enable
//   i_cfg_band          band index for the shadow write
//   i_cfg_idx           0=b1 1=b2 2=b3 3=a2 4=a3 (5..7 ignored)
//   i_cfg_data          signed coefficient value
//   i_cfg_commit        request a shadow->active copy
//   i_ovr_clr           clears o_overrun and o_err (a same-cycle set wins)
//   o_eng_start         one-cycle engine start
//   o_eng_band          engine state-slot select (current band)
//   o_eng_x             engine input sample for the current band
//   o_b1..o_a3          active coefficients for the current band
//   i_eng_done          engine result pulse
//   i_eng_y             engine result, valid with i_eng_done
//   o_audio             final output sample
//   o_audio_valid       one-cycle pulse when o_audio updates
//   o_busy              high in every state except IDLE
//   o_commit_pending    commit requested but not yet applied
//   o_overrun           sticky: a strobe arrived while busy (sample dropped)
//   o_err               sticky: the engine timed out
// -----------------------------------------------------------------------------
module iir_band_sequencer #(
   parameter int                       NBANDS   = 3,
   parameter int                       COEF_W   = 18,
   parameter logic signed [COEF_W-1:0] COEF_ONE = 18'sh10000,
   parameter int                       TIMEOUT  = 255
) (
   input  logic                        clk,
   input  logic                        i_rst,
   input  logic                        i_sample_strobe,
   input  logic signed [15:0]          i_sample,
   input  logic                        i_valid,
   input  logic                        i_cfg_we,
   input  logic [$clog2(NBANDS)-1:0]   i_cfg_band,
   input  logic [2:0]                  i_cfg_idx,
   input  logic signed [COEF_W-1:0]    i_cfg_data,
   input  logic                        i_cfg_commit,
   input  logic                        i_ovr_clr,
   output logic                        o_eng_start,
   output logic [$clog2(NBANDS)-1:0]   o_eng_band,
   output logic signed [15:0]          o_eng_x,
   output logic signed [COEF_W-1:0]    o_b1,
   output logic signed [COEF_W-1:0]    o_b2,
   output logic signed [COEF_W-1:0]    o_b3,
   output logic signed [COEF_W-1:0]    o_a2,
   output logic signed [COEF_W-1:0]    o_a3,
   input  logic                        i_eng_done,
   input  logic signed [15:0]          i_eng_y,
   output logic signed [15:0]          o_audio,
   output logic                        o_audio_valid,
   output logic                        o_busy,
   output logic                        o_commit_pending,
   output logic                        o_overrun,
   output logic                        o_err
);

   localparam int               BW        = $clog2(NBANDS);
   localparam int               NCOEF     = 5;
   localparam int               CW        = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0]    LAST_BAND = BW'(NBANDS - 1);
   localparam logic [BW:0]      BAND_LIM  = (BW + 1)'(NBANDS);
   localparam logic [CW-1:0]    WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;

   logic [BW-1:0]            r_band;
   logic signed [15:0]       r_x;
   logic signed [15:0]       r_orig;
   logic signed [15:0]       r_audio;
   logic                     r_audio_valid;
   logic [CW-1:0]            r_wcnt;
   logic                     r_pending;
   logic                     r_overrun;
   logic                     r_err;

   logic signed [COEF_W-1:0] r_shadow [NBANDS][NCOEF];
   logic signed [COEF_W-1:0] r_active [NBANDS][NCOEF];

   logic                     w_accept;
   logic                     w_bypass;
   logic                     w_step;
   logic                     w_timeout;
   logic                     w_copy;
   logic                     w_cfg_hit;
   logic                     w_ovr_set;

   // State register
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_bypass    = 1'b0;
      w_step      = 1'b0;
      w_timeout   = 1'b0;
      o_eng_start = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_sample_strobe) begin
               if (i_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_bypass = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            o_eng_start = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle still counts.
            if (i_eng_done) begin
               w_step      = 1'b1;
               w_state_nxt = (r_band == LAST_BAND) ? S_OUT : S_ISSUE;
            end else if (r_wcnt == WAIT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_ovr_set = i_sample_strobe && (r_state != S_IDLE);
   assign w_copy    = (r_state == S_IDLE) && r_pending;
   assign w_cfg_hit = i_cfg_we && ({1'b0, i_cfg_band} < BAND_LIM) && (i_cfg_idx < 3'd5);

   // Sample path, band sequencing, wait timer, flags
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_band        <= '0;
         r_x           <= '0;
         r_orig        <= '0;
         r_audio       <= '0;
         r_audio_valid <= 1'b0;
         r_wcnt        <= '0;
         r_pending     <= 1'b0;
         r_overrun     <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_audio_valid <= 1'b0;

         if (w_accept) begin
            r_x    <= i_sample;
            r_orig <= i_sample;
            r_band <= '0;
         end

         if (w_bypass) begin
            r_audio       <= i_sample;
            r_audio_valid <= 1'b1;
         end

         if (r_state == S_ISSUE) begin
            r_wcnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_wcnt <= r_wcnt + CW'(1);
         end

         // o_audio and its valid pulse are loaded on the edge into OUT, so
         // the pulse is visible during the OUT cycle itself.
         if (w_step) begin
            r_x <= i_eng_y;
            if (r_band == LAST_BAND) begin
               r_audio       <= i_eng_y;
               r_audio_valid <= 1'b1;
            end else begin
               r_band <= r_band + BW'(1);
            end
         end

         // An aborted cascade publishes the untouched input sample.
         if (w_timeout) begin
            r_audio       <= r_orig;
            r_audio_valid <= 1'b1;
         end

         // The copy already includes any write landing in the same cycle,
         // so a commit arriving alongside the copy is fully absorbed.
         r_pending <= w_copy ? 1'b0 : (r_pending | i_cfg_commit);
         r_overrun <= w_ovr_set | (r_overrun & ~i_ovr_clr);
         r_err     <= w_timeout | (r_err & ~i_ovr_clr);
      end
   end

   // Coefficient banks
   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int b = 0; b < NBANDS; b++) begin
            for (int k = 0; k < NCOEF; k++) begin
               r_shadow[b][k] <= (k == 0) ? COEF_ONE : '0;
               r_active[b][k] <= (k == 0) ? COEF_ONE : '0;
            end
         end
      end else begin
         for (int b = 0; b < NBANDS; b++) begin
            for (int k = 0; k < NCOEF; k++) begin
               if (w_cfg_hit && (i_cfg_band == BW'(b)) && (i_cfg_idx == 3'(k))) begin
                  r_shadow[b][k] <= i_cfg_data;
               end
               if (w_copy) begin
                  if (w_cfg_hit && (i_cfg_band == BW'(b)) && (i_cfg_idx == 3'(k))) begin
                     r_active[b][k] <= i_cfg_data;
                  end else begin
                     r_active[b][k] <= r_shadow[b][k];
                  end
               end
            end
         end
      end
   end

   assign o_eng_band       = r_band;
   assign o_eng_x          = r_x;
   assign o_b1             = r_active[r_band][0];
   assign o_b2             = r_active[r_band][1];
   assign o_b3             = r_active[r_band][2];
   assign o_a2             = r_active[r_band][3];
   assign o_a3             = r_active[r_band][4];
   assign o_audio          = r_audio;
   assign o_audio_valid    = r_audio_valid;
   assign o_commit_pending = r_pending;
   assign o_overrun        = r_overrun;
   assign o_err            = r_err;

endmodule

// File: doc/iir_band_sequencer.md
Name: iir_band_sequencer

Overview:
- Time-multiplexes one shared biquad IIR engine across NBANDS cascaded equalizer bands, once per audio sample.
- Sits between the I2S/lrclk front end (one-cycle sample strobe) and the shared IIR engine.
- Owns a double-buffered coefficient bank (b1,b2,b3,a2,a3 per band) written by the host/UI logic.
- Feeds each band's output into the next band and publishes the final output with a valid pulse.

Parameters:
- NBANDS, 3, number of cascaded bands (2..8)
- COEF_W, 18, signed coefficient width
- COEF_ONE, 18'sh10000, reset coefficient value for b1 (unity in Q2.16); b2,b3,a2,a3 reset to 0
- TIMEOUT, 255, max cycles in WAIT before abort

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_sample_strobe  in  1  one-cycle pulse per new sample (derived from lrclk edge)
- i_sample  in  16  signed input sample, valid with strobe
- i_valid  in  1  filter enable; 0 = bypass, sampled at strobe
- i_cfg_we  in  1  shadow coefficient write
- i_cfg_band  in  $clog2(NBANDS)  band index for write
- i_cfg_idx  in  3  0=b1 1=b2 2=b3 3=a2 4=a3; 5..7 ignored
- i_cfg_data  in  COEF_W  signed coefficient
- i_cfg_commit  in  1  request shadow->active copy
- i_ovr_clr  in  1  clears o_overrun and o_err
- o_eng_start  out  1  one-cycle start to engine
- o_eng_band  out  $clog2(NBANDS)  engine state-slot select
- o_eng_x  out  16  signed engine input
- o_b1,o_b2,o_b3,o_a2,o_a3  out  COEF_W each  active coefficients for current band
- i_eng_done  in  1  engine result pulse
- i_eng_y  in  16  signed engine result, valid with done
- o_audio  out  16  signed final output
- o_audio_valid  out  1  one-cycle pulse when o_audio updates
- o_busy  out  1  high in any state except IDLE
- o_commit_pending  out  1  commit requested, not yet applied
- o_overrun  out  1  sticky: strobe arrived while busy
- o_err  out  1  sticky: engine timeout occurred

Behaviour:
- Reset: all outputs 0; state IDLE; band counter 0; shadow and active banks = b1 COEF_ONE, others 0; pending, sticky flags cleared.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: on strobe with i_valid=1, latch i_sample into x register, band=0, go ISSUE. Strobe with i_valid=0: o_audio<=i_sample, o_audio_valid=1 next cycle, stay IDLE (bypass, engine untouched).
- ISSUE: o_eng_start=1 for exactly one cycle; o_eng_band=band; o_eng_x=x register; coefficients = active[band]. All held stable through WAIT. Next state WAIT.
- WAIT: on i_eng_done: x<=i_eng_y; if band==NBANDS-1 go OUT, else band+1, go ISSUE. Done in any other state is ignored.
- Timeout: WAIT cycle count reaching TIMEOUT without done -> set o_err, o_audio<=original input sample, go OUT (abort cascade).
- OUT: o_audio<=x, o_audio_valid=1 for one cycle, go IDLE.
- Latency (engine done in first WAIT cycle): strobe at cycle t -> o_audio_valid at t+2*NBANDS+1 (t+7 for NBANDS=3).
- Overrun: strobe while not IDLE -> sample dropped, o_overrun set; current run unaffected.
- Coefficients: i_cfg_we writes shadow[band][idx] at the clock edge; band >= NBANDS or idx >= 5 ignored. i_cfg_commit sets pending.
- Pending copy occurs only in a cycle spent in IDLE, taking the whole bank atomically, then clears pending. An active bank never changes mid-sample.
- Same-cycle we+commit: the write is included in the commit.
- Strobe in the same IDLE cycle as the copy: that sample uses the new bank.
- i_ovr_clr clears both sticky flags. If a set event occurs in the same cycle, set wins.
- i_rst mid-run: immediate return to IDLE, no o_audio_valid, banks reset to defaults.

Test Plan:
- Unity passthrough: after reset, strobe i_sample=16'sh1234, i_valid=1, engine model echoes x. Required: three start pulses with o_eng_band 0,1,2; o_audio=16'sh1234; o_audio_valid at t+7.
- Bypass: i_valid=0, strobe i_sample=-100. Required: o_audio=-100 next cycle; o_eng_start never asserted.
- Cascade chaining: engine model returns x+1. Required: o_eng_x per band is 10,11,12; o_audio=13.
- Commit atomicity: commit band1 b1=18'sh08000 while busy. Required: o_commit_pending=1 until IDLE; current sample sees old value; next sample band1 o_b1=18'sh08000.
- Overrun + timeout: strobe during WAIT sets o_overrun. Engine silent 255 cycles: o_err=1, o_audio=original input, return to IDLE. i_ovr_clr clears both flags.
- Reset mid-WAIT: assert i_rst. Required: next cycle o_busy=0, no valid pulse, o_b1 of band 0 reads 18'sh10000.
